// File: rtl/wb_stage.sv
// Write-back stage: EX/WB register, RF/CSR write ports and WB->ID forwarding.
// Optional retired-instruction counter enabled by MILANO_WB_INSTRET_EN.
module wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter logic [63:0] INSTRET_INIT = 64'h0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] instr_addr_i,
    input  logic            rd_we_i,
    input  logic [4:0]      rd_waddr_i,
    input  logic [XLEN-1:0] rd_wdata_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            fwd_rs1_hit_o,
    output logic [XLEN-1:0] fwd_rs1_data_o,
    output logic            fwd_rs2_hit_o,
    output logic [XLEN-1:0] fwd_rs2_data_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic [63:0]     instret_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic            rd_we_q;
    logic [4:0]      rd_waddr_q;
    logic [XLEN-1:0] rd_wdata_q;
    logic            csr_we_q;
    logic [11:0]     csr_waddr_q;
    logic [XLEN-1:0] csr_wdata_q;

    logic bubble;
    logic rd_we_d;
    logic csr_we_d;

    assign bubble   = stall_i | flush_i;
    assign rd_we_d  = rd_we_i & instr_valid_i & (rd_waddr_i != 5'd0);
    assign csr_we_d = csr_we_i & instr_valid_i;

    // A bubble only clears the qualifiers; payload is left untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd_we_q     <= 1'b0;
            rd_waddr_q  <= '0;
            rd_wdata_q  <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
        end else if (bubble) begin
            valid_q  <= 1'b0;
            rd_we_q  <= 1'b0;
            csr_we_q <= 1'b0;
        end else begin
            valid_q     <= instr_valid_i;
            pc_q        <= instr_addr_i;
            rd_we_q     <= rd_we_d;
            rd_waddr_q  <= rd_waddr_i;
            rd_wdata_q  <= rd_wdata_i;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_i;
            csr_wdata_q <= csr_wdata_i;
        end
    end

    assign rf_we_o     = rd_we_q;
    assign rf_waddr_o  = rd_waddr_q;
    assign rf_wdata_o  = rd_wdata_q;
    assign csr_we_o    = csr_we_q;
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;
    assign wb_valid_o  = valid_q;
    assign wb_pc_o     = pc_q;

    // x0 never hits: rd_we_q is already cleared for index 0.
    assign fwd_rs1_hit_o  = rd_we_q & (rd_waddr_q == id_rs1_addr_i);
    assign fwd_rs2_hit_o  = rd_we_q & (rd_waddr_q == id_rs2_addr_i);
    assign fwd_rs1_data_o = fwd_rs1_hit_o ? rd_wdata_q : '0;
    assign fwd_rs2_data_o = fwd_rs2_hit_o ? rd_wdata_q : '0;

`ifdef MILANO_WB_INSTRET_EN
    logic [63:0] instret_q;
    logic        wr_lo;
    logic        wr_hi;

    assign wr_lo = csr_we_q & (csr_waddr_q == 12'hB02);
    assign wr_hi = csr_we_q & (csr_waddr_q == 12'hB82);

    // A CSR write to the counter replaces the increment for that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= INSTRET_INIT;
        end else if (wr_lo) begin
            instret_q[31:0] <= csr_wdata_q[31:0];
        end else if (wr_hi) begin
            instret_q[63:32] <= csr_wdata_q[31:0];
        end else if (valid_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    logic unused_instret_init;
    assign unused_instret_init = ^INSTRET_INIT;
    assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic against a behavioural model of the WB register and retire count.
module tb_wb_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, flush, ivalid;
    logic [XLEN-1:0] iaddr;
    logic            rd_we;
    logic [4:0]      rd_waddr;
    logic [XLEN-1:0] rd_wdata;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic [4:0]      rs1, rs2;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wcsr_we;
    logic [11:0]     wcsr_waddr;
    logic [XLEN-1:0] wcsr_wdata;
    logic            h1, h2;
    logic [XLEN-1:0] d1, d2;
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [63:0]     instret;

    int checks = 0;
    int errors = 0;

    // Reference model: what WB should hold and what the counter should read.
    logic            m_valid, m_rf_we, m_csr_we;
    logic [XLEN-1:0] m_pc, m_wdata, m_cdata;
    logic [4:0]      m_waddr;
    logic [11:0]     m_caddr;
    logic [63:0]     m_instret;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .INSTRET_INIT(64'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .stall_i(stall), .flush_i(flush),
        .instr_valid_i(ivalid), .instr_addr_i(iaddr),
        .rd_we_i(rd_we), .rd_waddr_i(rd_waddr), .rd_wdata_i(rd_wdata),
        .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .csr_we_o(wcsr_we), .csr_waddr_o(wcsr_waddr),
        .csr_wdata_o(wcsr_wdata),
        .fwd_rs1_hit_o(h1), .fwd_rs1_data_o(d1),
        .fwd_rs2_hit_o(h2), .fwd_rs2_data_o(d2),
        .wb_valid_o(wb_valid), .wb_pc_o(wb_pc), .instret_o(instret)
    );

    function automatic logic [63:0] exp_instret();
`ifdef MILANO_WB_INSTRET_EN
        return m_instret;
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rf_we = 0; m_csr_we = 0;
        m_pc = '0; m_wdata = '0; m_cdata = '0;
        m_waddr = '0; m_caddr = '0;
        m_instret = 64'h0;
    endtask

    task automatic idle();
        stall = 0; flush = 0; ivalid = 0; iaddr = '0;
        rd_we = 0; rd_waddr = '0; rd_wdata = '0;
        csr_we = 0; csr_waddr = '0; csr_wdata = '0;
        rs1 = '0; rs2 = '0;
    endtask

    // Advance one clock; model sees the same inputs the DUT captures.
    task automatic step();
        if (m_csr_we && m_caddr == 12'hB02)
            m_instret = {m_instret[63:32], m_cdata};
        else if (m_csr_we && m_caddr == 12'hB82)
            m_instret = {m_cdata, m_instret[31:0]};
        else if (m_valid)
            m_instret = m_instret + 64'd1;
        if (stall || flush) begin
            m_valid = 0; m_rf_we = 0; m_csr_we = 0;
        end else begin
            m_valid  = ivalid;
            m_pc     = iaddr;
            m_rf_we  = ivalid && rd_we && (rd_waddr != 0);
            m_waddr  = rd_waddr;
            m_wdata  = rd_wdata;
            m_csr_we = ivalid && csr_we;
            m_caddr  = csr_waddr;
            m_cdata  = csr_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1;
        idle();
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, wcsr_we, wcsr_waddr, wcsr_wdata,
             wb_valid, wb_pc, h1, d1, h2, d2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rf_we=%0b wb_valid=%0b",
                     rf_we, wb_valid);
        end
        checks++;
        if (instret !== 64'h0) begin
            errors++;
            $display("FAIL reset_instret got=%0h exp=0", instret);
        end
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_write();
        idle();
        ivalid = 1; iaddr = 32'h100; rd_we = 1;
        rd_waddr = 5; rd_wdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, wb_valid, wb_pc} !==
            {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL basic_write got we=%0b a=%0d d=%h v=%0b pc=%h",
                     rf_we, rf_waddr, rf_wdata, wb_valid, wb_pc);
        end
        idle();
        step();
        checks++;
        if (rf_we !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse got we=%0b v=%0b", rf_we, wb_valid);
        end
    endtask

    task automatic test_x0_invalid();
        idle();
        ivalid = 1; rd_we = 1; rd_waddr = 0; rd_wdata = 32'h55;
        step();
        checks++;
        if (rf_we !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL x0_write got we=%0b v=%0b exp we=0 v=1", rf_we, wb_valid);
        end
        ivalid = 0; rd_we = 1; rd_waddr = 6; csr_we = 1; csr_waddr = 12'h300;
        step();
        checks++;
        if (rf_we !== 1'b0 || wcsr_we !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_write got we=%0b cwe=%0b v=%0b exp 0",
                     rf_we, wcsr_we, wb_valid);
        end
        idle();
    endtask

    task automatic test_stall_flush();
        int writes;
        idle();
        ivalid = 1; rd_we = 1; rd_waddr = 9; rd_wdata = 32'hBAD0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble cyc=%0d got we=%0b v=%0b",
                         i, rf_we, wb_valid);
            end
        end
        stall = 0; rd_wdata = 32'h7;
        writes = 0;
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h7}) begin
            errors++;
            $display("FAIL stall_release got we=%0b a=%0d d=%h exp 1/9/7",
                     rf_we, rf_waddr, rf_wdata);
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            step();
            if (rf_we === 1'b1) writes++;
        end
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL stall_no_repeat got extra=%0d exp=0", writes);
        end
        ivalid = 1; rd_we = 1; rd_waddr = 10; rd_wdata = 32'h11;
        csr_we = 1; csr_waddr = 12'h340; flush = 1;
        step();
        checks++;
        if (rf_we !== 1'b0 || wcsr_we !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble got we=%0b cwe=%0b v=%0b exp 0",
                     rf_we, wcsr_we, wb_valid);
        end
        stall = 1;
        step();
        checks++;
        if (rf_we !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush_both got we=%0b v=%0b exp 0",
                     rf_we, wb_valid);
        end
        idle();
        step();
    endtask

    task automatic test_forwarding();
        idle();
        ivalid = 1; rd_we = 1; rd_waddr = 3; rd_wdata = 32'h1234;
        rs1 = 3; rs2 = 4;
        step();
        checks++;
        if (h1 !== 1'b1 || d1 !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_rs1 got hit=%0b d=%h exp 1/1234", h1, d1);
        end
        checks++;
        if (h2 !== 1'b0 || d2 !== 32'h0) begin
            errors++;
            $display("FAIL fwd_rs2 got hit=%0b d=%h exp 0/0", h2, d2);
        end
        ivalid = 1; rd_we = 1; rd_waddr = 0; rd_wdata = 32'hFFFF;
        rs1 = 0; rs2 = 0;
        step();
        checks++;
        if (h1 !== 1'b0 || h2 !== 1'b0 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL fwd_x0 got h1=%0b h2=%0b d1=%h exp 0", h1, h2, d1);
        end
        idle();
        step();
    endtask

    task automatic test_async_reset();
        idle();
        ivalid = 1; iaddr = 32'h200; rd_we = 1; rd_waddr = 12; rd_wdata = 32'hCAFE;
        csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'h8;
        rs1 = 12;
        step();
        idle();
        rs1 = 12;
        #3 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, wcsr_we, wcsr_waddr, wcsr_wdata,
             wb_valid, wb_pc, h1, d1} !== '0) begin
            errors++;
            $display("FAIL async_reset got we=%0b cwe=%0b v=%0b h1=%0b",
                     rf_we, wcsr_we, wb_valid, h1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rf_we !== 1'b0 || wcsr_we !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_hold got we=%0b cwe=%0b", rf_we, wcsr_we);
        end
        #2 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_instret();
        logic [63:0] e10, ewrap;
`ifdef MILANO_WB_INSTRET_EN
        e10 = 64'd10; ewrap = 64'h1_0000_0000;
`else
        e10 = 64'd0; ewrap = 64'd0;
`endif
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ivalid = 1; iaddr = 32'h1000 + 4 * i;
            step();
        end
        idle();
        step();
        checks++;
        if (instret !== e10) begin
            errors++;
            $display("FAIL instret_ten got=%0h exp=%0h", instret, e10);
        end
        ivalid = 1; csr_we = 1; csr_waddr = 12'hB02; csr_wdata = 32'hFFFF_FFFF;
        step();
        idle();
        ivalid = 1;
        step();
        idle();
        step();
        checks++;
        if (instret !== ewrap) begin
            errors++;
            $display("FAIL instret_carry got=%0h exp=%0h", instret, ewrap);
        end
        ivalid = 1; csr_we = 1; csr_waddr = 12'hB82; csr_wdata = 32'hFFFF_FFFF;
        step();
        idle();
        step();
        checks++;
        if (instret !== exp_instret()) begin
            errors++;
            $display("FAIL instret_hi_write got=%0h exp=%0h", instret, exp_instret());
        end
    endtask

    task automatic test_random();
        logic [11:0] csr_pick [4];
        csr_pick[0] = 12'hB02; csr_pick[1] = 12'hB82;
        csr_pick[2] = 12'h300; csr_pick[3] = 12'h341;
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            ivalid    = ($urandom_range(0, 4) != 0);
            iaddr     = $urandom;
            rd_we     = ($urandom_range(0, 9) < 7);
            rd_waddr  = 5'($urandom_range(0, 7));
            rd_wdata  = $urandom;
            csr_we    = ($urandom_range(0, 9) < 2);
            csr_waddr = csr_pick[$urandom_range(0, 3)];
            csr_wdata = $urandom;
            step();
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {m_rf_we, m_waddr, m_wdata}) begin
                errors++;
                $display("FAIL rand_rf cyc=%0d got %0b/%0d/%h exp %0b/%0d/%h", i,
                         rf_we, rf_waddr, rf_wdata, m_rf_we, m_waddr, m_wdata);
            end
            checks++;
            if ({wcsr_we, wcsr_waddr, wcsr_wdata} !==
                {m_csr_we, m_caddr, m_cdata}) begin
                errors++;
                $display("FAIL rand_csr cyc=%0d got %0b/%h/%h exp %0b/%h/%h", i,
                         wcsr_we, wcsr_waddr, wcsr_wdata, m_csr_we, m_caddr, m_cdata);
            end
            checks++;
            if ({wb_valid, wb_pc} !== {m_valid, m_pc}) begin
                errors++;
                $display("FAIL rand_wb cyc=%0d got %0b/%h exp %0b/%h", i,
                         wb_valid, wb_pc, m_valid, m_pc);
            end
            checks++;
            if ({h1, d1} !== {m_rf_we && m_waddr == rs1,
                              (m_rf_we && m_waddr == rs1) ? m_wdata : 32'h0} ||
                {h2, d2} !== {m_rf_we && m_waddr == rs2,
                              (m_rf_we && m_waddr == rs2) ? m_wdata : 32'h0}) begin
                errors++;
                $display("FAIL rand_fwd cyc=%0d got %0b/%h %0b/%h", i, h1, d1, h2, d2);
            end
            checks++;
            if (instret !== exp_instret()) begin
                errors++;
                $display("FAIL rand_instret cyc=%0d got=%0h exp=%0h", i,
                         instret, exp_instret());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0_invalid();
        test_stall_flush();
        test_forwarding();
        test_async_reset();
        test_instret();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
